led_arbiter: RTL and testbench

LED_ARBITER -- requirements
Module: led_arbiter

---
 rtl/led_pkg.sv | 30 +++
 rtl/led_tick_div.sv | 28 ++
 rtl/led_arbiter.sv | 124 ++++++++++++
 tb/tb_led_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings and helpers for the LED arbiter family.
// Round-robin pointer arithmetic and pattern selection live here so other LED blocks can reuse them.
package led_pkg;

    localparam int N_REQ = 3;
    localparam int LED_W = 3;
    localparam logic [LED_W-1:0] IDLE_PAT = 3'b001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        SWITCH = 2'd2
    } state_e;

    typedef logic [1:0] req_idx_t;

    function automatic req_idx_t rr_next(input req_idx_t idx);
        return (idx == req_idx_t'(N_REQ - 1)) ? '0 : idx + req_idx_t'(1);
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input req_idx_t idx);
        return N_REQ'(1) << idx;
    endfunction

    function automatic logic [LED_W-1:0] pat_of(input logic [N_REQ*LED_W-1:0] pat_all,
                                                input req_idx_t idx);
        return pat_all[idx*LED_W +: LED_W];
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// Free-running prescaler: tick is high for one cycle every DIV_FCTR cycles.
// tick decodes the counter combinationally; first tick lands DIV_FCTR cycles after reset.
module led_tick_div #(
    parameter int DIV_FCTR = 24_000_000
) (
    input  logic clk_in,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV_FCTR);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_FCTR - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    assign tick      = (div_cnt_q == CNT_MAX);
    assign div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of a shared LED; owners keep it for at least SLOT_TICKS ticks.
// Registered outputs, one-cycle pat->led_out latency; no backpressure, requests are held levels.
module led_arbiter
    import led_pkg::*;
#(
    parameter int DIV_FCTR   = 24_000_000,
    parameter int SLOT_TICKS = 4
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*LED_W-1:0]  pat,
    output logic [N_REQ-1:0]        gnt,
    output logic                    busy,
    output logic [LED_W-1:0]        led_out
);

    localparam int SLOT_W = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SLOT_TICKS - 1);
    localparam req_idx_t PTR_RST = req_idx_t'(N_REQ - 1);

    logic tick;

    state_e             state_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [LED_W-1:0]   led_q;
    logic [SLOT_W-1:0]  slot_cnt_q;
    logic [SLOT_W-1:0]  slot_cnt_d;
    req_idx_t           ptr_q;

    logic               win_vld;
    req_idx_t           win_idx;
    req_idx_t           cand;
    logic               slot_end;
    logic               preempt;
    logic               release_own;

    led_tick_div #(
        .DIV_FCTR (DIV_FCTR)
    ) u_tick_div (
        .clk_in (clk_in),
        .rst    (rst),
        .tick   (tick)
    );

    // Search starts one past the last winner, so the previous owner is considered last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            cand = rr_next(cand);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // ptr_q doubles as the owner index while in OWN.
    assign slot_end    = (slot_cnt_q == SLOT_MAX);
    assign preempt     = slot_end && tick && (|(req & ~gnt_q));
    assign release_own = !req[ptr_q];
    assign slot_cnt_d  = tick ? (slot_end ? '0 : slot_cnt_q + SLOT_W'(1)) : slot_cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            led_q      <= IDLE_PAT;
            slot_cnt_q <= '0;
            ptr_q      <= PTR_RST;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q    <= OWN;
                        gnt_q      <= onehot(win_idx);
                        led_q      <= pat_of(pat, win_idx);
                        slot_cnt_q <= '0;
                        ptr_q      <= win_idx;
                    end else if (tick) begin
                        led_q <= {led_q[0], led_q[LED_W-1:1]};
                    end
                end
                OWN: begin
                    // Release and pre-emption share one exit, so they never stack into two gaps.
                    if (release_own || preempt) begin
                        state_q <= SWITCH;
                        gnt_q   <= '0;
                        led_q   <= '0;
                    end else begin
                        led_q      <= pat_of(pat, ptr_q);
                        slot_cnt_q <= slot_cnt_d;
                    end
                end
                SWITCH: begin
                    if (win_vld) begin
                        state_q    <= OWN;
                        gnt_q      <= onehot(win_idx);
                        led_q      <= pat_of(pat, win_idx);
                        slot_cnt_q <= '0;
                        ptr_q      <= win_idx;
                    end else begin
                        state_q <= IDLE;
                        led_q   <= IDLE_PAT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    led_q   <= IDLE_PAT;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign busy    = |gnt_q;
    assign led_out = led_q;

    gnt_onehot_a: assert property (@(posedge clk_in) disable iff (rst) $onehot0(gnt_q));

endmodule

// File: tb/tb_led_arbiter.sv
// Directed scoreboard bench for led_arbiter with DIV_FCTR=4, SLOT_TICKS=2.
// Expectations are keyed by edge number counted from the last reset edge of the initial reset.
module tb_led_arbiter;

    localparam int K0 = 3;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [8:0] pat;
    logic [2:0] gnt;
    logic       busy;
    logic [2:0] led_out;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        logic [2:0] gnt;
        logic [2:0] led;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    led_arbiter #(
        .DIV_FCTR   (4),
        .SLOT_TICKS (2)
    ) dut (
        .clk_in  (clk),
        .rst     (rst),
        .req     (req),
        .pat     (pat),
        .gnt     (gnt),
        .busy    (busy),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic ex(input int k, input logic [2:0] g, input logic [2:0] l, input string nm);
        exp_t e;
        e.cyc  = K0 + k;
        e.gnt  = g;
        e.led  = l;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic go_to(input int k);
        while (cyc < K0 + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: invariants every cycle plus queued expectations for the current edge.
    always @(negedge clk) begin
        if (cyc >= K0) begin
            n_chk++;
            if (!$onehot0(gnt)) begin
                n_err++;
                $display("FAIL onehot edge=%0d gnt=%b required at most one bit set", cyc - K0, gnt);
            end
            n_chk++;
            if (busy !== (|gnt)) begin
                n_err++;
                $display("FAIL busy_eq edge=%0d busy=%b required=%b", cyc - K0, busy, (|gnt));
            end
        end
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            n_chk++;
            if (e.cyc != cyc) begin
                n_err++;
                $display("FAIL %s missed edge=%0d now=%0d", e.name, e.cyc - K0, cyc - K0);
            end else if (gnt !== e.gnt || led_out !== e.led || busy !== (|e.gnt)) begin
                n_err++;
                $display("FAIL %s edge=%0d gnt=%b busy=%b led=%b required gnt=%b busy=%b led=%b",
                         e.name, cyc - K0, gnt, busy, led_out, e.gnt, (|e.gnt), e.led);
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = 3'b000;
        pat = 9'b110_011_101;

        // Reset and idle rotation
        go_to(0);
        rst = 1'b0;
        ex(0,  3'b000, 3'b001, "reset_state");
        ex(3,  3'b000, 3'b001, "idle_hold");
        ex(4,  3'b000, 3'b100, "idle_rot1");
        ex(7,  3'b000, 3'b100, "idle_rot1_hold");
        ex(8,  3'b000, 3'b010, "idle_rot2");
        ex(12, 3'b000, 3'b001, "idle_rot3");

        // Single grant, pattern follow, slot expiry with nobody waiting, release
        go_to(13);
        req = 3'b001;
        ex(14, 3'b001, 3'b101, "grant0");
        go_to(15);
        pat[2:0] = 3'b111;
        ex(15, 3'b001, 3'b101, "own_hold");
        ex(16, 3'b001, 3'b111, "pat_follow");
        ex(20, 3'b001, 3'b111, "slot_retain");
        go_to(21);
        req = 3'b000;
        pat[2:0] = 3'b101;
        ex(22, 3'b000, 3'b000, "release_gap");
        ex(23, 3'b000, 3'b001, "idle_reentry");
        ex(24, 3'b000, 3'b100, "idle_rot_after");

        // Pre-emption and round-robin regain
        go_to(25);
        req = 3'b001;
        ex(26, 3'b001, 3'b101, "grant0_again");
        go_to(26);
        req = 3'b011;
        ex(31, 3'b001, 3'b101, "no_early_preempt");
        ex(32, 3'b000, 3'b000, "preempt_gap");
        ex(33, 3'b010, 3'b011, "grant1");
        ex(39, 3'b010, 3'b011, "own1_hold");
        ex(40, 3'b000, 3'b000, "preempt_gap2");
        ex(41, 3'b001, 3'b101, "rr_regain0");

        // Release coincident with slot expiry
        go_to(47);
        req = 3'b010;
        ex(48, 3'b000, 3'b000, "simul_gap");
        ex(49, 3'b010, 3'b011, "simul_grant1");
        ex(50, 3'b010, 3'b011, "no_double_gap");

        // Non-owner toggle away from a pre-emption point
        go_to(50);
        req = 3'b110;
        go_to(51);
        req = 3'b010;
        ex(52, 3'b010, 3'b011, "toggle_ignored");
        ex(56, 3'b010, 3'b011, "retain_after_toggle");

        // Fairness with all requesters active
        go_to(57);
        req = 3'b111;
        ex(60, 3'b010, 3'b011, "fair_hold1");
        ex(64, 3'b000, 3'b000, "fair_gap1");
        ex(65, 3'b100, 3'b110, "fair_g2");
        ex(72, 3'b000, 3'b000, "fair_gap2");
        ex(73, 3'b001, 3'b101, "fair_g0");
        ex(80, 3'b000, 3'b000, "fair_gap3");
        ex(81, 3'b010, 3'b011, "fair_g1");
        ex(87, 3'b010, 3'b011, "fair_hold1b");
        ex(88, 3'b000, 3'b000, "fair_gap4");
        ex(89, 3'b100, 3'b110, "fair_g2b");

        // Reset pulse while requester 2 owns
        go_to(90);
        rst = 1'b1;
        ex(91, 3'b000, 3'b001, "reset_mid_own");
        go_to(91);
        rst = 1'b0;
        ex(92,  3'b001, 3'b101, "post_reset_grant0");
        ex(98,  3'b001, 3'b101, "post_reset_slot");
        ex(99,  3'b000, 3'b000, "post_reset_preempt");
        ex(100, 3'b010, 3'b011, "post_reset_grant1");

        go_to(100);
        req = 3'b000;
        ex(101, 3'b000, 3'b000, "final_gap");
        ex(102, 3'b000, 3'b001, "final_idle");

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (sb_q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
